regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_SRC writeback sources, such as the ALU, the load unit and the CSR unit.
- Each source presents a valid/ready request. A round-robin arbiter grants at most one source per cycle.
- The granted request is registered and driven onto the register file write port (write_en/write_addr/write_data) one cycle later.
- Writes to x0 are suppressed. A saturating counter records arbitration contention for performance analysis.

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the result sources and the register file write port.
// Sources drive the src_* request side; the arbiter answers with src_ready and drives write_*.
interface regfile_wb_arbiter_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 3
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*WIDTH-1:0]  src_data;
    logic                      write_en;
    logic [ADDR_W-1:0]         write_addr;
    logic [WIDTH-1:0]          write_data;

    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, write_en, write_addr, write_data
    );

    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, write_en, write_addr, write_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_SRC writeback
// sources, with a registered write port, x0 suppression and a saturating contention counter.
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  wb,
    output logic [IDX_W-1:0]     last_grant,
    output logic [CNT_W-1:0]     conflict_cnt
);

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [IDX_W-1:0]  lg_q, lg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IDX_W-1:0]   cand [NUM_SRC];
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] ready;
    logic               xfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic               multi_valid;

    function automatic int unsigned wrap_idx(input int unsigned v);
        return (v >= NUM_SRC) ? v - NUM_SRC : v;
    endfunction

    // Search order starting at the pointer, wrapping modulo NUM_SRC.
    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand[k] = IDX_W'(wrap_idx(32'(rr_ptr_q) + k));
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!grant_vld && wb.src_valid[cand[k]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[k];
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ready[i] = reset_n && grant_vld && (grant_idx == IDX_W'(i));
        end
    end

    assign xfer = |ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ready[i]) begin
                sel_addr = wb.src_addr[i*ADDR_W +: ADDR_W];
                sel_data = wb.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more requests are valid.
    assign multi_valid = |(wb.src_valid & (wb.src_valid - NUM_SRC'(1)));

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        lg_d     = lg_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
            wen_d    = |sel_addr;
            waddr_d  = sel_addr;
            wdata_d  = sel_data;
            lg_d     = grant_idx;
        end
        if (multi_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            lg_q     <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            lg_q     <= lg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wb.src_ready  = ready;
    assign wb.write_en   = wen_q;
    assign wb.write_addr = waddr_q;
    assign wb.write_data = wdata_q;
    assign last_grant    = lg_q;
    assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level reference model;
// a second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk;
    logic reset_n;
    logic [N-1:0]    t_valid;
    logic [N*AW-1:0] t_addr;
    logic [N*DW-1:0] t_data;

    logic [1:0]  lg_a, lg_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    regfile_wb_arbiter_if #(.WIDTH(DW), .ADDR_W(AW), .NUM_SRC(N)) bus_a ();
    regfile_wb_arbiter_if #(.WIDTH(DW), .ADDR_W(AW), .NUM_SRC(N)) bus_b ();

    assign bus_a.src_valid = t_valid;
    assign bus_a.src_addr  = t_addr;
    assign bus_a.src_data  = t_data;
    assign bus_b.src_valid = t_valid;
    assign bus_b.src_addr  = t_addr;
    assign bus_b.src_data  = t_data;

    regfile_wb_arbiter #(.WIDTH(DW), .ADDR_W(AW), .NUM_SRC(N), .CNT_W(16)) dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb           (bus_a.slave),
        .last_grant   (lg_a),
        .conflict_cnt (cnt_a)
    );

    regfile_wb_arbiter #(.WIDTH(DW), .ADDR_W(AW), .NUM_SRC(N), .CNT_W(4)) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb           (bus_b.slave),
        .last_grant   (lg_b),
        .conflict_cnt (cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_lg;
    int          m_cnt16;
    int          m_cnt4;
    int          last_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (t_valid[i] == 1'b1) return i;
        end
        return -1;
    endfunction

    task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        t_valid[i]          = v;
        t_addr[i*AW +: AW]  = a;
        t_data[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'd0);
    endtask

    // One clock: check at negedge, advance the model, return at posedge+1.
    task automatic tick(input logic rst_v);
        int g;
        logic [N-1:0] exp_rdy;
        reset_n = rst_v;
        @(negedge clk);
        g = model_grant();
        exp_rdy = '0;
        if (rst_v && g >= 0) exp_rdy = N'(1) << g;
        chk("ready_a", 64'(bus_a.src_ready), 64'(exp_rdy));
        chk("ready_b", 64'(bus_b.src_ready), 64'(exp_rdy));
        chk("write_en", 64'(bus_a.write_en), 64'(m_wen));
        chk("write_addr", 64'(bus_a.write_addr), 64'(m_waddr));
        chk("write_data", 64'(bus_a.write_data), 64'(m_wdata));
        chk("last_grant", 64'(lg_a), 64'(m_lg));
        chk("cnt16", 64'(cnt_a), 64'(m_cnt16));
        chk("cnt4", 64'(cnt_b), 64'(m_cnt4));
        chk("write_en_b", 64'(bus_b.write_en), 64'(m_wen));
        chk("last_grant_b", 64'(lg_b), 64'(m_lg));
        if (!rst_v) begin
            m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
            m_lg = 0; m_cnt16 = 0; m_cnt4 = 0; last_g = -1;
        end else begin
            if (g >= 0) begin
                m_ptr   = (g + 1) % N;
                m_waddr = t_addr[g*AW +: AW];
                m_wdata = t_data[g*DW +: DW];
                m_wen   = (m_waddr != 5'd0);
                m_lg    = g;
            end else begin
                m_wen = 1'b0;
            end
            if ($countones(t_valid) >= 2) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            last_g = g;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        t_valid = '0; t_addr = '0; t_data = '0;
        m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        m_lg = 0; m_cnt16 = 0; m_cnt4 = 0; last_g = -1;

        // Reset with every source requesting
        set_src(0, 1'b1, 5'd1, 32'hA);
        set_src(1, 1'b1, 5'd2, 32'hB);
        set_src(2, 1'b1, 5'd3, 32'hC);
        tick(1'b0);
        tick(1'b0);
        chk("rst_wen", 64'(bus_a.write_en), 64'd0);
        chk("rst_cnt", 64'(cnt_a), 64'd0);

        // Round-robin, all continuously valid
        repeat (6) tick(1'b1);
        chk("rr_cnt", 64'(cnt_a), 64'd6);
        chk("rr_lg", 64'(lg_a), 64'd2);
        chk("rr_waddr", 64'(bus_a.write_addr), 64'd3);

        // Single requester after idle
        clear_all();
        tick(1'b1);
        set_src(2, 1'b1, 5'd7, 32'hDEADBEEF);
        tick(1'b1);
        clear_all();
        chk("single_wen", 64'(bus_a.write_en), 64'd1);
        chk("single_addr", 64'(bus_a.write_addr), 64'd7);
        chk("single_data", 64'(bus_a.write_data), 64'hDEADBEEF);
        chk("single_lg", 64'(lg_a), 64'd2);

        // x0 write completes handshake but is suppressed; pointer moves to 2
        set_src(1, 1'b1, 5'd0, 32'h1234);
        tick(1'b1);
        clear_all();
        chk("x0_wen", 64'(bus_a.write_en), 64'd0);
        chk("x0_lg", 64'(lg_a), 64'd1);
        set_src(0, 1'b1, 5'd1, 32'hA);
        set_src(1, 1'b1, 5'd2, 32'hB);
        set_src(2, 1'b1, 5'd3, 32'hC);
        tick(1'b1);
        chk("x0_ptr", 64'(lg_a), 64'd2);
        clear_all();

        // Stalled source 1 waits behind source 0
        set_src(0, 1'b1, 5'd5, 32'h55);
        set_src(1, 1'b1, 5'd6, 32'h66);
        tick(1'b1);
        chk("stall_first", 64'(lg_a), 64'd0);
        set_src(0, 1'b0, 5'd0, 32'd0);
        tick(1'b1);
        chk("stall_addr", 64'(bus_a.write_addr), 64'd6);
        chk("stall_data", 64'(bus_a.write_data), 64'h66);
        chk("stall_lg", 64'(lg_a), 64'd1);
        clear_all();

        // Counter saturation on the 4-bit instance
        set_src(0, 1'b1, 5'd1, 32'hA);
        set_src(1, 1'b1, 5'd2, 32'hB);
        set_src(2, 1'b1, 5'd3, 32'hC);
        repeat (20) tick(1'b1);
        chk("sat4", 64'(cnt_b), 64'd15);
        clear_all();

        // Reset discards a write already on the port
        set_src(0, 1'b1, 5'd9, 32'h99);
        tick(1'b1);
        clear_all();
        chk("pre_rst_wen", 64'(bus_a.write_en), 64'd1);
        tick(1'b0);
        chk("mid_rst_wen", 64'(bus_a.write_en), 64'd0);

        // Random traffic obeying the hold-until-granted rule
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!t_valid[i] && $urandom_range(1, 0) == 1)
                    set_src(i, 1'b1, 5'($urandom), $urandom);
            end
            tick(($urandom_range(63, 0) != 0) ? 1'b1 : 1'b0);
            if (last_g >= 0) begin
                if ($urandom_range(1, 0) == 1)
                    set_src(last_g, 1'b1, 5'($urandom), $urandom);
                else
                    set_src(last_g, 1'b0, 5'd0, 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
